// File: rtl/serial_inner_product_ctrl.sv
// serial_inner_product_ctrl
//   Time-multiplexed inner-product engine. It accepts one flattened window over
//   a valid/ready handshake and runs one signed MAC per cycle against a locally
//   held weight vector. The result is presented over a valid/ready handshake.
//   Weights are loaded at run time through the cfg_* write port.
//
//   Optional build macro: INNER_PROD_RELU_EN. When it is defined, a negative
//   final sum is clamped to 0 as the engine enters DONE. The clamp is applied
//   after the modulo-2^Q_WIDTH wrap.
//
// Ports
//   clk, rst_n          clock (rising edge) / asynchronous active-low reset
//   in_valid, in_ready  window handshake; input_data element i at [D_WIDTH*i +: D_WIDTH]
//   out_valid, out_ready, output_data   result handshake, signed Q_WIDTH
//   cfg_we, cfg_addr, cfg_wdata         weight write port; only honoured in IDLE
//   cfg_ready           weight writes are honoured this cycle
//   busy                engine is in ACCUM or DONE
module serial_inner_product_ctrl #(
  parameter int SIZE    = 9,
  parameter int D_WIDTH = 8,
  parameter int Q_WIDTH = 20,
  localparam int AW     = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [D_WIDTH*SIZE-1:0]   input_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [Q_WIDTH-1:0]        output_data,
  input  logic                      cfg_we,
  input  logic [AW-1:0]             cfg_addr,
  input  logic [D_WIDTH-1:0]        cfg_wdata,
  output logic                      cfg_ready,
  output logic                      busy
);

  localparam int              PW       = (Q_WIDTH > 2*D_WIDTH) ? Q_WIDTH : 2*D_WIDTH;
  localparam logic [AW:0]     SIZE_L   = (AW+1)'(SIZE);
  localparam logic [AW-1:0]   LAST_IDX = AW'(SIZE-1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t                          r_state, w_state_nxt;
  logic [SIZE-1:0][D_WIDTH-1:0]    r_x, r_w;
  logic signed [Q_WIDTH-1:0]       r_acc;
  logic [AW-1:0]                   r_idx;

  logic                            w_accept, w_last, w_cfg_hit;
  logic signed [D_WIDTH-1:0]       w_xe, w_we;
  logic signed [2*D_WIDTH-1:0]     w_prod;
  logic signed [PW-1:0]            w_prod_ext;
  logic signed [Q_WIDTH-1:0]       w_prod_q, w_sum, w_acc_fin;

  assign w_accept  = in_valid & in_ready;
  assign w_last    = (r_idx == LAST_IDX);
  assign w_cfg_hit = cfg_we & cfg_ready & ({1'b0, cfg_addr} < SIZE_L);

  // One MAC per cycle. The product is resized to Q_WIDTH: it is sign-extended
  // when Q_WIDTH is wider, and truncated (modulo wrap) when it is narrower.
  assign w_xe       = r_x[r_idx];
  assign w_we       = r_w[r_idx];
  assign w_prod     = w_xe * w_we;
  assign w_prod_ext = PW'(w_prod);
  assign w_prod_q   = w_prod_ext[Q_WIDTH-1:0];
  assign w_sum      = r_acc + w_prod_q;

`ifdef INNER_PROD_RELU_EN
  assign w_acc_fin = w_sum[Q_WIDTH-1] ? '0 : w_sum;
`else
  assign w_acc_fin = w_sum;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_ACCUM;
      S_ACCUM: if (w_last)   w_state_nxt = S_DONE;
      // A consumer pop and a new window can meet in the same cycle, so no bubble is needed.
      S_DONE:  if (out_ready) w_state_nxt = in_valid ? S_ACCUM : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = 1'b0;
    cfg_ready = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE:  begin in_ready = 1'b1; cfg_ready = 1'b1; end
      S_ACCUM: busy = 1'b1;
      S_DONE:  begin in_ready = out_ready; out_valid = 1'b1; busy = 1'b1; end
      default: ;
    endcase
  end

  assign output_data = r_acc;

  // Datapath. input_data is captured only at the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x   <= '0;
      r_acc <= '0;
      r_idx <= '0;
    end else if (w_accept) begin
      r_x   <= input_data;
      r_acc <= '0;
      r_idx <= '0;
    end else if (r_state == S_ACCUM) begin
      r_acc <= w_last ? w_acc_fin : w_sum;
      r_idx <= w_last ? '0 : r_idx + AW'(1);
    end
  end

  // Weight bank. Writes can only happen in IDLE, and no MAC reads the bank
  // before the first ACCUM cycle. A write in the same cycle as an accept is
  // therefore seen by that window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w <= '0;
    end else if (w_cfg_hit) begin
      for (int i = 0; i < SIZE; i++)
        if (cfg_addr == AW'(i)) r_w[i] <= cfg_wdata;
    end
  end

endmodule

// File: tb/tb_serial_inner_product_ctrl.sv
module tb_serial_inner_product_ctrl;
  localparam int D = 8;
  localparam int SA = 4, QA = 20;
  localparam int SB = 1, QB = 14;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: SIZE=4, Q=20
  logic            a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [D*SA-1:0] a_input_data;
  logic [QA-1:0]   a_output_data;
  logic            a_cfg_we, a_cfg_ready, a_busy;
  logic [1:0]      a_cfg_addr;
  logic [D-1:0]    a_cfg_wdata;

  // Instance B: SIZE=1, Q=14 (exercises wrap and out-of-range address)
  logic            b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [D*SB-1:0] b_input_data;
  logic [QB-1:0]   b_output_data;
  logic            b_cfg_we, b_cfg_ready, b_busy;
  logic [0:0]      b_cfg_addr;
  logic [D-1:0]    b_cfg_wdata;

  serial_inner_product_ctrl #(.SIZE(SA), .D_WIDTH(D), .Q_WIDTH(QA)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .input_data(a_input_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .output_data(a_output_data),
    .cfg_we(a_cfg_we), .cfg_addr(a_cfg_addr), .cfg_wdata(a_cfg_wdata),
    .cfg_ready(a_cfg_ready), .busy(a_busy));

  serial_inner_product_ctrl #(.SIZE(SB), .D_WIDTH(D), .Q_WIDTH(QB)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .input_data(b_input_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .output_data(b_output_data),
    .cfg_we(b_cfg_we), .cfg_addr(b_cfg_addr), .cfg_wdata(b_cfg_wdata),
    .cfg_ready(b_cfg_ready), .busy(b_busy));

  typedef struct {
    logic [3:0][7:0] x;
    logic [3:0][7:0] w;
    longint          exp;
  } vec_t;

  vec_t tv[5];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic longint relu(input longint v);
`ifdef INNER_PROD_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input int addr, input logic [7:0] d);
    a_cfg_we = 1'b1; a_cfg_addr = 2'(addr); a_cfg_wdata = d;
    step();
    a_cfg_we = 1'b0;
  endtask

  task automatic load_w_a(input logic [3:0][7:0] w);
    for (int i = 0; i < 4; i++) wr_a(i, w[i]);
  endtask

  // Accept edge happens inside; afterwards input_data is scrambled.
  task automatic send_a(input logic [3:0][7:0] x);
    a_input_data = x; a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0; a_input_data = $urandom();
  endtask

  task automatic wait_a(input string nm, input int exp_lat);
    int lat = 0;
    while (!a_out_valid && lat < 20) begin
      chk({nm, " in_ready busy-phase"}, a_in_ready, 0);
      chk({nm, " busy"}, a_busy, 1);
      step();
      lat++;
    end
    chk({nm, " latency"}, lat, exp_lat);
  endtask

  task automatic pop_a(input string nm, input longint exp);
    chk({nm, " out_valid"}, a_out_valid, 1);
    chk({nm, " result"}, $signed(a_output_data), exp);
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;
    chk({nm, " out_valid after pop"}, a_out_valid, 0);
  endtask

  task automatic run_b(input string nm, input logic [7:0] x, input longint exp);
    int lat = 0;
    b_input_data = x; b_in_valid = 1'b1;
    step();
    b_in_valid = 1'b0; b_input_data = $urandom();
    while (!b_out_valid && lat < 20) begin step(); lat++; end
    chk({nm, " latency"}, lat, 1);
    chk({nm, " result"}, $signed(b_output_data), exp);
    b_out_ready = 1'b1;
    step();
    b_out_ready = 1'b0;
  endtask

  localparam logic [3:0][7:0] W1234 = {8'd4, 8'd3, 8'd2, 8'd1};
  localparam logic [3:0][7:0] ONES  = {8'd1, 8'd1, 8'd1, 8'd1};

  initial begin
    tv[0] = '{x: ONES, w: W1234, exp: 10};
    tv[1] = '{x: {4{8'h80}}, w: {4{8'h80}}, exp: 65536};
    tv[2] = '{x: {4{8'h7F}}, w: {4{8'h80}}, exp: -65024};
    tv[3] = '{x: {8'h00, 8'h05, 8'hFE, 8'h03}, w: W1234, exp: 14};
    tv[4] = '{x: '0, w: {8'h11, 8'h22, 8'h33, 8'h44}, exp: 0};

    rst_n = 1'b0;
    a_in_valid = 0; a_out_ready = 0; a_input_data = '0; a_cfg_we = 0; a_cfg_addr = '0; a_cfg_wdata = '0;
    b_in_valid = 0; b_out_ready = 0; b_input_data = '0; b_cfg_we = 0; b_cfg_addr = '0; b_cfg_wdata = '0;
    repeat (2) step();

    chk("reset out_valid", a_out_valid, 0);
    chk("reset busy", a_busy, 0);
    chk("reset in_ready", a_in_ready, 1);
    chk("reset cfg_ready", a_cfg_ready, 1);
    chk("reset output_data", a_output_data, 0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // Table-driven vectors
    for (int i = 0; i < 5; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      load_w_a(tv[i].w);
      send_a(tv[i].x);
      wait_a(nm, 4);
      pop_a(nm, relu(tv[i].exp));
    end

    // Backpressure, then back-to-back accept on the pop cycle
    load_w_a(W1234);
    send_a(ONES);
    wait_a("bp", 4);
    a_input_data = {8'd0, 8'd0, 8'd0, 8'd2}; a_in_valid = 1'b1;
    repeat (5) begin
      chk("bp hold result", $signed(a_output_data), 10);
      chk("bp hold out_valid", a_out_valid, 1);
      chk("bp hold in_ready", a_in_ready, 0);
      step();
    end
    a_out_ready = 1'b1;
    #1;
    chk("b2b in_ready", a_in_ready, 1);
    step();
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_input_data = $urandom();
    chk("b2b no bubble busy", a_busy, 1);
    wait_a("b2b", 4);
    pop_a("b2b", 2);

    // Weight write while busy is dropped
    load_w_a(W1234);
    send_a(ONES);
    a_cfg_we = 1'b1; a_cfg_addr = 2'd1; a_cfg_wdata = 8'd7;
    #1;
    chk("busy cfg_ready", a_cfg_ready, 0);
    step();
    a_cfg_we = 1'b0;
    wait_a("busywr", 3);
    pop_a("busywr", 10);
    send_a(ONES);
    wait_a("busywr2", 4);
    pop_a("busywr2", 10);

    // Write and accept in the same IDLE cycle: new weight is used
    a_cfg_we = 1'b1; a_cfg_addr = 2'd1; a_cfg_wdata = 8'd7;
    a_input_data = ONES; a_in_valid = 1'b1;
    step();
    a_cfg_we = 1'b0; a_in_valid = 1'b0;
    wait_a("samewr", 4);
    pop_a("samewr", 15);

    // Clamp / raw negative
    load_w_a({8'd0, 8'd0, 8'd0, 8'hFF});
    send_a({8'd0, 8'd0, 8'd0, 8'd5});
    wait_a("relu", 4);
    pop_a("relu", relu(-5));

    // SIZE=1 instance: out-of-range write dropped, wrap at Q=14
    b_cfg_we = 1'b1; b_cfg_addr = 1'b0; b_cfg_wdata = 8'd3;
    step();
    b_cfg_addr = 1'b1; b_cfg_wdata = 8'd9;
    step();
    b_cfg_we = 1'b0;
    run_b("b oob", 8'hFB, relu(-15));
    b_cfg_we = 1'b1; b_cfg_addr = 1'b0; b_cfg_wdata = 8'h80;
    step();
    b_cfg_we = 1'b0;
    run_b("b wrap", 8'h80, 0);

    // Reset in the middle of ACCUM
    load_w_a(W1234);
    send_a(ONES);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", a_out_valid, 0);
    chk("midrst busy", a_busy, 0);
    chk("midrst in_ready", a_in_ready, 1);
    chk("midrst output_data", a_output_data, 0);
    @(negedge clk) rst_n = 1'b1;
    step();
    send_a(ONES);
    wait_a("postrst", 4);
    pop_a("postrst", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
